// File: rtl/ctr_monitor_if.sv
// Signal bundle between an observed up/down counter and its sequence monitor.
// The master side presents the count stream; the slave side is the monitor.
interface ctr_monitor_if #(
   parameter int WIDTH         = 3,
   parameter int ERR_CNT_WIDTH = 8
);
   logic                     enable;
   logic [WIDTH-1:0]         count;
   logic                     clr_err;
   logic                     locked;
   logic                     dir;
   logic                     step_err;
   logic                     wrap;
   logic [ERR_CNT_WIDTH-1:0] err_cnt;

   modport master (
      output enable, count, clr_err,
      input  locked, dir, step_err, wrap, err_cnt
   );

   modport slave (
      input  enable, count, clr_err,
      output locked, dir, step_err, wrap, err_cnt
   );
endinterface

// File: rtl/ctr_monitor.sv
// Passive up/down counter sequence monitor: acquires a counting direction,
// locks after LOCK_LEN consistent steps, then flags breaks and wrap-arounds.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_EMPTY | no valid previous sample; next sample only seeds prev
//   ST_ACQ   | counting consistent steps in dir until run reaches LOCK_LEN
//   ST_TRACK | locked; each sample must continue the sequence in dir
module ctr_monitor #(
   parameter int WIDTH         = 3,
   parameter int LOCK_LEN      = 2,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   ctr_monitor_if.slave mon
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ACQ   = 2'd1,
      ST_TRACK = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0]         CNT_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0]         CNT_ONES = '1;
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE  = ERR_CNT_WIDTH'(1);
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;
   localparam logic [3:0]               LOCK_RUN = 4'(LOCK_LEN);

   state_t                   state, state_nxt;
   logic [WIDTH-1:0]         prev, prev_nxt;
   logic [3:0]               run, run_nxt;
   logic                     dir_q, dir_nxt;
   logic                     step_err_q, step_err_nxt;
   logic                     wrap_q, wrap_nxt;
   logic [ERR_CNT_WIDTH-1:0] err_q, err_nxt;

   logic [WIDTH-1:0]         prev_inc;
   logic [WIDTH-1:0]         prev_dec;
   logic                     step_up;
   logic                     step_dn;
   logic                     step_match;
   logic                     wrap_step;
   logic [3:0]               acq_run;
   logic                     acq_dir;
   logic                     violation;

   // Modulo-2^WIDTH neighbours of the previous sample.
   assign prev_inc   = prev + CNT_ONE;
   assign prev_dec   = prev - CNT_ONE;
   assign step_up    = (mon.count == prev_inc);
   assign step_dn    = (mon.count == prev_dec);
   assign step_match = dir_q ? step_dn : step_up;
   assign wrap_step  = dir_q ? ((prev == '0) && (mon.count == CNT_ONES))
                             : ((prev == CNT_ONES) && (mon.count == '0));

   // A step continues the run only if it agrees with dir and a run is open.
   always_comb begin
      acq_run = 4'd0;
      acq_dir = dir_q;
      if (step_up || step_dn) begin
         if ((step_dn == dir_q) && (run != 4'd0)) begin
            acq_run = run + 4'd1;
         end else begin
            acq_dir = step_dn;
            acq_run = 4'd1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      prev_nxt     = prev;
      run_nxt      = run;
      dir_nxt      = dir_q;
      step_err_nxt = 1'b0;
      wrap_nxt     = 1'b0;
      violation    = 1'b0;
      if (mon.enable) begin
         prev_nxt = mon.count;
         case (state)
            ST_EMPTY: begin
               run_nxt   = 4'd0;
               state_nxt = ST_ACQ;
            end
            ST_ACQ: begin
               run_nxt = acq_run;
               dir_nxt = acq_dir;
               if (acq_run == LOCK_RUN) begin
                  state_nxt = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (step_match) begin
                  wrap_nxt = wrap_step;
               end else begin
                  violation    = 1'b1;
                  step_err_nxt = 1'b1;
                  run_nxt      = 4'd0;
                  state_nxt    = ST_ACQ;
               end
            end
            default: begin
               run_nxt   = 4'd0;
               state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // Clear wins over a coincident violation; the tally saturates at all-ones.
   always_comb begin
      err_nxt = err_q;
      if (mon.clr_err) begin
         err_nxt = '0;
      end else if (violation && (err_q != ERR_MAX)) begin
         err_nxt = err_q + ERR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_EMPTY;
         prev       <= '0;
         run        <= 4'd0;
         dir_q      <= 1'b0;
         step_err_q <= 1'b0;
         wrap_q     <= 1'b0;
         err_q      <= '0;
      end else begin
         state      <= state_nxt;
         prev       <= prev_nxt;
         run        <= run_nxt;
         dir_q      <= dir_nxt;
         step_err_q <= step_err_nxt;
         wrap_q     <= wrap_nxt;
         err_q      <= err_nxt;
      end
   end

   assign mon.locked   = (state == ST_TRACK);
   assign mon.dir      = dir_q;
   assign mon.step_err = step_err_q;
   assign mon.wrap     = wrap_q;
   assign mon.err_cnt  = err_q;

endmodule

// File: tb/tb_ctr_monitor.sv
// Bench for ctr_monitor: directed scenarios followed by random count streams,
// all checked against a behavioural model of the monitor's rules.
module tb_ctr_monitor;

   localparam int W    = 3;
   localparam int LOCK = 2;
   localparam int MOD  = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic [W-1:0] count = '0;
   logic         clr_err = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   ctr_monitor_if #(.WIDTH(W), .ERR_CNT_WIDTH(8)) if8 ();
   ctr_monitor_if #(.WIDTH(W), .ERR_CNT_WIDTH(2)) if2 ();

   assign if8.enable  = enable;
   assign if8.count   = count;
   assign if8.clr_err = clr_err;
   assign if2.enable  = enable;
   assign if2.count   = count;
   assign if2.clr_err = clr_err;

   ctr_monitor #(.WIDTH(W), .LOCK_LEN(LOCK), .ERR_CNT_WIDTH(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .mon (if8)
   );

   ctr_monitor #(.WIDTH(W), .LOCK_LEN(LOCK), .ERR_CNT_WIDTH(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .mon (if2)
   );

   always #5 clk = ~clk;

   // Reference model: outputs expected after the upcoming rising edge.
   bit m_have;
   bit m_locked;
   bit m_dir;
   bit m_step;
   bit m_wrap;
   int m_prev;
   int m_run;
   int m_err8;
   int m_err2;

   task automatic check_val(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit en, input int c, input bit clr);
      int  diff;
      bit  viol;
      bit  is_up;
      bit  is_dn;
      viol   = 1'b0;
      m_step = 1'b0;
      m_wrap = 1'b0;
      if (r) begin
         m_have = 0; m_locked = 0; m_dir = 0; m_prev = 0; m_run = 0;
         m_err8 = 0; m_err2 = 0;
         return;
      end
      if (en) begin
         if (!m_have) begin
            m_have = 1;
            m_run  = 0;
         end else begin
            diff  = (c - m_prev + MOD) % MOD;
            is_up = (diff == 1);
            is_dn = (diff == MOD - 1);
            if (m_locked) begin
               if ((is_up && !m_dir) || (is_dn && m_dir)) begin
                  m_wrap = (!m_dir && c == 0) || (m_dir && c == MOD - 1);
               end else begin
                  viol     = 1'b1;
                  m_step   = 1'b1;
                  m_locked = 0;
                  m_run    = 0;
               end
            end else if (is_up || is_dn) begin
               if (is_dn == m_dir && m_run > 0) begin
                  m_run++;
               end else begin
                  m_dir = is_dn;
                  m_run = 1;
               end
               if (m_run == LOCK) m_locked = 1;
            end else begin
               m_run = 0;
            end
         end
         m_prev = c;
      end
      if (clr) begin
         m_err8 = 0;
         m_err2 = 0;
      end else if (viol) begin
         if (m_err8 < 255) m_err8++;
         if (m_err2 < 3)   m_err2++;
      end
   endtask

   task automatic apply(input bit r, input bit en, input int c, input bit clr);
      @(negedge clk);
      rst     = r;
      enable  = en;
      count   = W'(c);
      clr_err = clr;
      model_step(r, en, c % MOD, clr);
      @(posedge clk);
      #1;
      check_val("locked",   int'(if8.locked),   int'(m_locked));
      check_val("dir",      int'(if8.dir),      int'(m_dir));
      check_val("step_err", int'(if8.step_err), int'(m_step));
      check_val("wrap",     int'(if8.wrap),     int'(m_wrap));
      check_val("err_cnt8", int'(if8.err_cnt),  m_err8);
      check_val("err_cnt2", int'(if2.err_cnt),  m_err2);
      check_val("locked2",  int'(if2.locked),   int'(m_locked));
   endtask

   task automatic sample(input int c);
      apply(1'b0, 1'b1, c, 1'b0);
   endtask

   initial begin
      int v;
      int cur;
      bit down;
      int p;
      bit r;
      bit en;
      bit clr;

      // reset state
      apply(1'b1, 1'b0, 0, 1'b0);
      apply(1'b1, 1'b1, 5, 1'b0);
      check_val("rst_locked", int'(if8.locked), 0);
      check_val("rst_err", int'(if8.err_cnt), 0);

      // ascending lock and wrap
      sample(0);
      sample(1);
      check_val("asc_not_yet", int'(if8.locked), 0);
      sample(2);
      check_val("asc_lock", int'(if8.locked), 1);
      check_val("asc_dir", int'(if8.dir), 0);
      for (int i = 3; i <= 7; i++) sample(i);
      sample(0);
      check_val("asc_wrap", int'(if8.wrap), 1);
      check_val("asc_err", int'(if8.err_cnt), 0);
      sample(1);
      check_val("asc_wrap_pulse", int'(if8.wrap), 0);

      // descending lock and wrap
      apply(1'b1, 1'b0, 0, 1'b0);
      sample(5); sample(4); sample(3);
      check_val("dsc_lock", int'(if8.locked), 1);
      check_val("dsc_dir", int'(if8.dir), 1);
      sample(2); sample(1); sample(0); sample(7);
      check_val("dsc_wrap", int'(if8.wrap), 1);

      // skip violation then relock
      apply(1'b1, 1'b0, 0, 1'b0);
      sample(1); sample(2); sample(3);
      sample(5);
      check_val("skip_err", int'(if8.step_err), 1);
      check_val("skip_cnt", int'(if8.err_cnt), 1);
      check_val("skip_unlock", int'(if8.locked), 0);
      sample(6);
      sample(7);
      check_val("skip_relock", int'(if8.locked), 1);

      // gaps with a varying count, then an enabled repeat
      for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, $urandom_range(0, MOD - 1), 1'b0);
      check_val("gap_locked", int'(if8.locked), 1);
      sample(7);
      check_val("stall_err", int'(if8.step_err), 1);
      check_val("stall_cnt", int'(if8.err_cnt), 2);

      // saturation of the narrow tally and clear priority
      apply(1'b1, 1'b0, 0, 1'b0);
      v = 0;
      sample(v);
      for (int k = 0; k < 5; k++) begin
         sample((v + 1) % MOD);
         sample((v + 2) % MOD);
         sample((v + 2) % MOD);
         v = (v + 2) % MOD;
      end
      check_val("sat_cnt2", int'(if2.err_cnt), 3);
      check_val("sat_cnt8", int'(if8.err_cnt), 5);
      sample((v + 1) % MOD);
      sample((v + 2) % MOD);
      apply(1'b0, 1'b1, (v + 2) % MOD, 1'b1);
      check_val("clr_cnt", int'(if2.err_cnt), 0);
      check_val("clr_step", int'(if2.step_err), 1);

      // reset while tracking
      sample(3); sample(4); sample(5);
      check_val("pre_rst_lock", int'(if8.locked), 1);
      apply(1'b1, 1'b1, 6, 1'b0);
      check_val("mid_rst_lock", int'(if8.locked), 0);
      sample(6); sample(7);
      check_val("relock_wait", int'(if8.locked), 0);
      sample(0);
      check_val("relock_done", int'(if8.locked), 1);

      // random count streams with gaps, glitches, clears and resets
      cur  = $urandom_range(0, MOD - 1);
      down = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 59) == 0);
         if (en) begin
            p = $urandom_range(0, 19);
            if (p == 15) down = ~down;
            if (p <= 15) cur = down ? (cur + MOD - 1) % MOD : (cur + 1) % MOD;
            else if (p >= 17) cur = $urandom_range(0, MOD - 1);
            apply(r, 1'b1, cur, clr);
         end else begin
            apply(r, 1'b0, $urandom_range(0, MOD - 1), clr);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
